// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared types and constants for the memory access unit: FSM
//            state encoding, funct3 size/sign codes, access-size decode and
//            the default bus timeout.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // FSM states of the access unit
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Access width, encoded as log2(bytes)
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_t;

  // funct3 size/sign codes
  localparam logic [2:0] c_f3_b  = 3'b000;
  localparam logic [2:0] c_f3_h  = 3'b001;
  localparam logic [2:0] c_f3_w  = 3'b010;
  localparam logic [2:0] c_f3_d  = 3'b011;
  localparam logic [2:0] c_f3_bu = 3'b100;
  localparam logic [2:0] c_f3_hu = 3'b101;
  localparam logic [2:0] c_f3_wu = 3'b110;

  // Bus cycles allowed in REQ before an access is abandoned
  localparam int c_timeout_default = 16;

  // Stores have no unsigned variants, so any 1xx store is a doubleword;
  // 111 is a doubleword for loads too.
  function automatic size_t access_size(input logic [2:0] f3, input logic is_store);
    size_t sz;
    if (f3 == 3'b111 || (is_store && f3[2])) begin
      sz = SZ_D;
    end else begin
      sz = size_t'(f3[1:0]);
    end
    return sz;
  endfunction

  function automatic logic is_aligned(input size_t sz, input logic [2:0] off);
    logic ok;
    case (sz)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = (off[0] == 1'b0);
      SZ_W:    ok = (off[1:0] == 2'b00);
      default: ok = (off == 3'b000);
    endcase
    return ok;
  endfunction

  // Byte-enable pattern for an access at lane 0
  function automatic logic [7:0] byte_mask(input size_t sz);
    logic [7:0] m;
    case (sz)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_if
// Purpose  : Doubleword memory bus between the access unit and memory.
// Ports    : bus_req/bus_we/bus_addr/bus_be/bus_wdata  unit -> memory
//            bus_ack/bus_rdata                         memory -> unit
// Modports : master (access unit), slave (memory model / fabric)
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [7:0]  bus_be;
  logic [63:0] bus_wdata;
  logic        bus_ack;
  logic [63:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module   : load_align
// Purpose  : Combinational load lane extraction: shifts the addressed lanes
//            of a bus doubleword down to bit 0 and sign/zero-extends them.
// Ports    : rdata  [63:0] in   doubleword from the bus
//            offset [2:0]  in   byte offset within the doubleword
//            funct3 [2:0]  in   load size/sign code
//            result [63:0] out  extended load value
// Revision : 1.0 - initial release
// ============================================================================
module load_align
  import mem_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  output logic [63:0] result
);

  logic [63:0] w_shifted;

  assign w_shifted = rdata >> {offset, 3'b000};

  always_comb begin
    result = w_shifted;
    case (funct3)
      c_f3_b:  result = {{56{w_shifted[7]}},  w_shifted[7:0]};
      c_f3_h:  result = {{48{w_shifted[15]}}, w_shifted[15:0]};
      c_f3_w:  result = {{32{w_shifted[31]}}, w_shifted[31:0]};
      c_f3_bu: result = {56'd0, w_shifted[7:0]};
      c_f3_hu: result = {48'd0, w_shifted[15:0]};
      c_f3_wu: result = {32'd0, w_shifted[31:0]};
      default: result = w_shifted;  // d and 111: full doubleword
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Load/store unit between decode/execute and a doubleword memory
//            bus. Checks alignment, issues one bus cycle per access, holds
//            the pipeline with stall, aligns load data and abandons an
//            access after TIMEOUT bus cycles without acknowledge.
// Ports    : clk, reset (async, active low)
//            MemRead, MemWrite, funct3, address, write_data  from decode
//            read_data                                       to write-back
//            stall, misaligned, bus_err                      status
//            bus (mem_access_unit_if.master)                 memory bus
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = c_timeout_default
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemRead,
  input  logic                     MemWrite,
  input  logic [2:0]               funct3,
  input  logic [63:0]              address,
  input  logic [63:0]              write_data,
  output logic [63:0]              read_data,
  output logic                     stall,
  output logic                     misaligned,
  output logic                     bus_err,
  mem_access_unit_if.master        bus
);

  localparam int c_cnt_w = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

  // ---------------------------------------------------------------- decode
  logic        w_access;
  logic        w_store;
  size_t       w_size;
  logic [2:0]  w_offset;
  logic        w_aligned;
  logic        w_start;
  logic [7:0]  w_be;
  logic [63:0] w_wdata;

  // Both strobes high is a store
  assign w_access  = MemRead | MemWrite;
  assign w_store   = MemWrite;
  assign w_size    = access_size(funct3, w_store);
  assign w_offset  = address[2:0];
  assign w_aligned = is_aligned(w_size, w_offset);
  assign w_start   = w_access & w_aligned;
  assign w_be      = byte_mask(w_size) << w_offset;
  assign w_wdata   = write_data << {w_offset, 3'b000};

  // ---------------------------------------------------------------- state
  state_t             r_state;
  state_t             w_next;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_bus_req;
  logic               r_bus_we;
  logic [63:0]        r_bus_addr;
  logic [7:0]         r_bus_be;
  logic [63:0]        r_bus_wdata;
  logic [63:0]        r_read_data;
  logic               r_bus_err;
  logic               r_load;
  logic [2:0]         r_off;
  logic [2:0]         r_f3;
  logic               w_ack_take;
  logic               w_timeout;
  logic [63:0]        w_load_result;

  load_align u_load_align (
    .rdata  (bus.bus_rdata),
    .offset (r_off),
    .funct3 (r_f3),
    .result (w_load_result)
  );

  // Next state; bus_ack only matters in REQ, so stray acks elsewhere fall away
  always_comb begin
    w_next     = r_state;
    w_ack_take = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_next = ST_REQ;
      end
      ST_REQ: begin
        if (bus.bus_ack) begin
          w_next     = ST_DONE;
          w_ack_take = 1'b1;
        end else if (r_cnt == c_cnt_last) begin
          w_next    = ST_DONE;
          w_timeout = 1'b1;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= '0;
      r_bus_wdata <= '0;
      r_read_data <= '0;
      r_bus_err   <= 1'b0;
      r_load      <= 1'b0;
      r_off       <= '0;
      r_f3        <= '0;
    end else begin
      r_state   <= w_next;
      r_bus_err <= w_timeout;  // high only for the DONE cycle after timeout
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= w_store;
            r_bus_addr  <= {address[63:3], 3'b000};
            r_bus_be    <= w_be;
            r_bus_wdata <= w_wdata;
            r_cnt       <= '0;
            r_read_data <= '0;
            r_load      <= MemRead & ~MemWrite;
            r_off       <= w_offset;
            r_f3        <= funct3;
          end
        end
        ST_REQ: begin
          if (w_next == ST_DONE) begin
            r_bus_req   <= 1'b0;
            // Stores and timeouts return zero
            r_read_data <= (w_ack_take && r_load) ? w_load_result : '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  assign stall      = ((r_state == ST_IDLE) && w_start) || (r_state == ST_REQ);
  assign misaligned = w_access & ~w_aligned;
  // A misaligned access never reaches the bus; its result is forced to zero
  assign read_data  = misaligned ? '0 : r_read_data;
  assign bus_err    = r_bus_err;

  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_be    = r_bus_be;
  assign bus.bus_wdata = r_bus_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit: directed accesses,
//            misalignment, timeout, reset mid-access and randomized traffic
//            compared with a behavioural access model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [63:0] address, write_data;
  logic [63:0] read_data;
  logic        stall, misaligned, bus_err;

  int n_checks = 0;
  int n_errors = 0;

  // Values observed on the most recent access, for the constant cross-checks
  logic [63:0] last_rd, last_addr, last_wdata;
  logic [7:0]  last_be;
  logic        last_we;
  int          last_stalls;
  int          req_seen;

  mem_access_unit_if bus_if ();

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .funct3     (funct3),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .stall      (stall),
    .misaligned (misaligned),
    .bus_err    (bus_err),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ------------------------------------------------------------- model
  function automatic int size_bytes(input bit wr, input bit [2:0] f3);
    if (f3 == 3'd7 || (wr && f3 >= 3'd4)) return 8;
    return 1 << (f3 % 4);
  endfunction

  function automatic logic [63:0] load_value(input logic [63:0] rdata, input int off,
                                             input bit [2:0] f3);
    int bits;
    logic [63:0] v, mask;
    bits = size_bytes(1'b0, f3) * 8;
    v = rdata >> (8 * off);
    if (bits == 64) return v;
    mask = (64'd1 << bits) - 64'd1;
    v = v & mask;
    if (f3 < 3'd4 && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  // Entered and left at a negedge with the unit idle.
  // ack_at: REQ cycle (1-based) carrying bus_ack, 0 for no acknowledge.
  task automatic do_access(input bit rd, input bit wr, input bit [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] wd,
                           input logic [63:0] rdata, input int ack_at, input string nm);
    int sz, off, limit;
    bit aligned, is_load;
    logic [7:0]  exp_be;
    logic [63:0] exp_rd, exp_wdata;
    sz        = size_bytes(wr, f3);
    off       = int'(addr[2:0]);
    aligned   = (addr % sz) == 0;
    is_load   = rd && !wr;
    exp_be    = 8'((64'd1 << sz) - 64'd1) << off;
    exp_wdata = wd << (8 * off);
    exp_rd    = (is_load && ack_at > 0) ? load_value(rdata, off, f3) : 64'd0;
    limit     = (ack_at > 0) ? ack_at : TO;

    MemRead = rd; MemWrite = wr; funct3 = f3; address = addr; write_data = wd;
    #1;
    check({nm, ":misaligned"}, misaligned, !aligned);
    check({nm, ":stall_idle"}, stall, aligned);
    last_stalls = stall ? 1 : 0;
    req_seen = 0;

    if (!aligned) begin
      check({nm, ":rd_mis"}, read_data, 64'd0);
      repeat (3) begin
        @(posedge clk); #1;
        bus_if.bus_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (bus_if.bus_req) req_seen++;
        check({nm, ":req_mis"}, bus_if.bus_req, 1'b0);
        check({nm, ":stall_mis"}, stall, 1'b0);
      end
      @(posedge clk); #1;
      bus_if.bus_ack = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
      @(negedge clk);
      return;
    end

    for (int k = 1; k <= limit; k++) begin
      @(posedge clk); #1;
      bus_if.bus_ack = 1'b0;
      @(negedge clk);
      if (stall) last_stalls++;
      check({nm, ":req"}, bus_if.bus_req, 1'b1);
      check({nm, ":stall_req"}, stall, 1'b1);
      if (k == 1 || k == limit) begin
        check({nm, ":addr"}, bus_if.bus_addr, addr & ~64'h7);
        check({nm, ":be"}, bus_if.bus_be, exp_be);
        check({nm, ":we"}, bus_if.bus_we, wr);
        if (wr) check({nm, ":wdata"}, bus_if.bus_wdata, exp_wdata);
      end
      last_addr = bus_if.bus_addr; last_be = bus_if.bus_be;
      last_we = bus_if.bus_we; last_wdata = bus_if.bus_wdata;
      check({nm, ":err_req"}, bus_err, 1'b0);
      if (k == ack_at) begin
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = rdata;
      end else begin
        bus_if.bus_rdata = {$urandom, $urandom};
      end
    end

    // DONE: a stray ack here must be ignored
    @(posedge clk); #1;
    bus_if.bus_ack   = 1'($urandom_range(0, 1));
    bus_if.bus_rdata = {$urandom, $urandom};
    @(negedge clk);
    if (stall) last_stalls++;
    check({nm, ":stall_done"}, stall, 1'b0);
    check({nm, ":req_done"}, bus_if.bus_req, 1'b0);
    check({nm, ":err_done"}, bus_err, ack_at == 0);
    check({nm, ":rdata"}, read_data, exp_rd);
    last_rd = read_data;

    // IDLE with no request
    @(posedge clk); #1;
    bus_if.bus_ack = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    check({nm, ":err_idle"}, bus_err, 1'b0);
    check({nm, ":req_idle"}, bus_if.bus_req, 1'b0);
    check({nm, ":stall_idle2"}, stall, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'd0;
    address = 64'd0; write_data = 64'd0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 64'd0;
    repeat (3) @(negedge clk);
    check("rst:req", bus_if.bus_req, 1'b0);
    check("rst:we", bus_if.bus_we, 1'b0);
    check("rst:be", bus_if.bus_be, 8'h00);
    check("rst:addr", bus_if.bus_addr, 64'd0);
    check("rst:rdata", read_data, 64'd0);
    check("rst:err", bus_err, 1'b0);
    check("rst:stall", stall, 1'b0);
    rst_n = 1'b1;

    // ld 0x100, ack on second REQ cycle (first edge after release starts it)
    do_access(1, 0, 3'b011, 64'h100, 64'd0, 64'h1122334455667788, 2, "ld");
    check("ld:value", last_rd, 64'h1122334455667788);
    check("ld:stall_cycles", last_stalls, 3);

    // minimum latency: ack on first REQ cycle
    do_access(1, 0, 3'b011, 64'h208, 64'd0, 64'hCAFE, 1, "ld_fast");
    check("ld_fast:stall_cycles", last_stalls, 2);

    do_access(1, 0, 3'b000, 64'h103, 64'd0, 64'h0000000080000000, 1, "lb");
    check("lb:be", last_be, 8'h08);
    check("lb:value", last_rd, 64'hFFFFFFFFFFFFFF80);
    do_access(1, 0, 3'b100, 64'h103, 64'd0, 64'h0000000080000000, 1, "lbu");
    check("lbu:value", last_rd, 64'h80);

    do_access(0, 1, 3'b001, 64'h106, 64'hBEEF, 64'd0, 3, "sh");
    check("sh:we", last_we, 1'b1);
    check("sh:be", last_be, 8'hC0);
    check("sh:wdata_hi", last_wdata[63:48], 16'hBEEF);
    check("sh:addr", last_addr, 64'h100);
    check("sh:rdata", last_rd, 64'd0);

    do_access(1, 0, 3'b010, 64'h102, 64'd0, 64'd0, 1, "lw_mis");
    check("lw_mis:no_req", req_seen, 0);

    do_access(1, 0, 3'b011, 64'h300, 64'd0, 64'd0, 0, "ld_to");
    check("ld_to:rdata", last_rd, 64'd0);

    do_access(1, 1, 3'b011, 64'h400, 64'h55, 64'hFFFF, 1, "both");
    do_access(0, 1, 3'b110, 64'h104, 64'h1, 64'd0, 1, "sw_d_mis");
    do_access(1, 0, 3'b111, 64'h510, 64'd0, 64'h8000000000000001, 2, "l111");

    // reset during REQ, stray ack after release
    MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b011; address = 64'h600;
    repeat (3) @(negedge clk);
    check("rmid:req_before", bus_if.bus_req, 1'b1);
    rst_n = 1'b0; MemRead = 1'b0;
    #1;
    check("rmid:req", bus_if.bus_req, 1'b0);
    check("rmid:addr", bus_if.bus_addr, 64'd0);
    check("rmid:stall", stall, 1'b0);
    check("rmid:err", bus_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      bus_if.bus_ack = (c == 2);
      bus_if.bus_rdata = 64'hDEAD;
      @(negedge clk);
      check("rmid:req_after", bus_if.bus_req, 1'b0);
      check("rmid:err_after", bus_err, 1'b0);
      check("rmid:rd_after", read_data, 64'd0);
    end
    @(posedge clk); #1; bus_if.bus_ack = 1'b0;
    @(negedge clk);
    do_access(1, 0, 3'b001, 64'h702, 64'd0, 64'h00000000FFFE0000, 1, "lh_post");
    check("lh_post:value", last_rd, 64'hFFFFFFFFFFFFFFFE);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      bit rd, wr;
      bit [2:0] f3;
      logic [63:0] a;
      int sel, sz, ack;
      sel = $urandom_range(0, 2);
      rd  = (sel != 1);
      wr  = (sel != 0);
      f3  = 3'($urandom_range(0, 7));
      a   = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) begin
        sz = size_bytes(wr, f3);
        a[2:0] = 3'(($urandom_range(0, 7) / sz) * sz);
      end
      ack = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
      do_access(rd, wr, f3, a, {$urandom, $urandom}, {$urandom, $urandom}, ack, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
